// File: rtl/sram_slot_arbiter_pkg.sv
// Shared types for the external SRAM slot arbiter.
package sram_slot_arbiter_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_DMA  = 2'd3
  } mem_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SLOT = 2'd1,
    ARB_REC  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_slot_arbiter_select.sv
// Priority selector for the SRAM port with DMA starvation promotion.
// Grant is combinational; the starvation count is registered.
module sram_arb_select
  import sram_slot_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       i_eval,
  input  logic       i_cpu_req,
  input  logic       i_vid_req,
  input  logic       i_vid_urgent,
  input  logic       i_dma_req,
  output logic       o_grant,
  output mem_owner_t o_owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;
  logic          w_dma_promote;

  assign w_dma_promote = (r_starve >= SW'(STARVE_MAX));

  // Fixed priority: urgent video, promoted DMA, then CPU > video > DMA.
  always_comb begin
    o_owner = OWN_NONE;
    if (i_vid_urgent && i_vid_req)      o_owner = OWN_VID;
    else if (i_dma_req && w_dma_promote) o_owner = OWN_DMA;
    else if (i_cpu_req)                  o_owner = OWN_CPU;
    else if (i_vid_req)                  o_owner = OWN_VID;
    else if (i_dma_req)                  o_owner = OWN_DMA;
    o_grant = i_eval && (o_owner != OWN_NONE);
  end

  // Count arbitrations DMA loses while requesting; saturate at the promotion level.
  always_ff @(posedge clk28) begin
    if (rst || !i_dma_req) begin
      r_starve <= '0;
    end else if (o_grant) begin
      if (o_owner == OWN_DMA)  r_starve <= '0;
      else if (!w_dma_promote) r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: rtl/sram_slot_arbiter.sv
// Slot scheduler for the single external SRAM port shared by CPU, video and DMA.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no access in flight; arbitrate every cycle
//   ARB_SLOT | access in flight; r_step counts LATENCY down to 0
//   ARB_REC  | one recovery cycle after a write, VD still driven
//
// Reads may re-arbitrate in their final cycle so back-to-back reads leave no gap.
module sram_slot_arbiter
  import sram_slot_arbiter_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_wait,
  input  logic              vid_req,
  input  logic              vid_urgent,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [1:0]        rdata_owner,
  output logic [ADDR_W-1:0] va,
  output logic [DATA_W-1:0] vd_out,
  output logic              vd_oe,
  input  logic [DATA_W-1:0] vd_in,
  output logic              n_vrd,
  output logic              n_vwr
);

  localparam int STEP_W = $clog2(LATENCY + 1);

  arb_state_t        r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  mem_owner_t        r_owner, r_rdata_owner, w_sel_owner;
  logic              r_wr;
  logic [ADDR_W-1:0] r_va;
  logic [DATA_W-1:0] r_vd_out, r_rdata;
  logic              r_n_vrd, r_n_vwr, r_vd_oe;
  logic              w_n_vrd_nxt, w_n_vwr_nxt, w_vd_oe_nxt;
  logic              r_rdata_valid, w_rdata_valid_nxt;
  logic              r_cpu_done, w_cpu_done_nxt;
  logic              r_vid_ack, r_dma_ack;
  logic              w_slot_end, w_eval, w_grant;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_slot_end = (r_state == ARB_SLOT) && (r_step == '0);
  assign w_eval     = (r_state == ARB_IDLE) || (w_slot_end && !r_wr);

  sram_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .clk28        (clk28),
    .rst          (rst),
    .i_eval       (w_eval),
    .i_cpu_req    (cpu_req),
    .i_vid_req    (vid_req),
    .i_vid_urgent (vid_urgent),
    .i_dma_req    (dma_req),
    .o_grant      (w_grant),
    .o_owner      (w_sel_owner)
  );

  // Route the winning requester's access fields toward the slot registers.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = vid_addr;
    w_sel_wdata = '0;
    case (w_sel_owner)
      OWN_CPU: begin
        w_sel_wr    = cpu_wr;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        w_sel_wr    = dma_wr;
        w_sel_addr  = dma_addr;
        w_sel_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  // Next state and next strobe/pulse values; a grant overrides the slot tail.
  always_comb begin
    w_state_nxt       = r_state;
    w_step_nxt        = r_step;
    w_n_vrd_nxt       = 1'b1;
    w_n_vwr_nxt       = 1'b1;
    w_vd_oe_nxt       = 1'b0;
    w_rdata_valid_nxt = 1'b0;
    w_cpu_done_nxt    = 1'b0;
    case (r_state)
      ARB_SLOT: begin
        if (r_step != '0) begin
          w_step_nxt = r_step - 1'b1;
          if (r_wr) begin
            w_vd_oe_nxt = 1'b1;
            // Write strobe low between the setup cycle and the final hold cycle.
            w_n_vwr_nxt = (w_step_nxt == '0);
          end else begin
            w_n_vrd_nxt = 1'b0;
          end
        end else begin
          w_cpu_done_nxt = (r_owner == OWN_CPU);
          if (r_wr) begin
            w_state_nxt = ARB_REC;
            w_vd_oe_nxt = 1'b1;
          end else begin
            w_state_nxt       = ARB_IDLE;
            w_rdata_valid_nxt = 1'b1;
          end
        end
      end
      ARB_REC:  w_state_nxt = ARB_IDLE;
      default:  ;
    endcase
    if (w_grant) begin
      w_state_nxt = ARB_SLOT;
      w_step_nxt  = STEP_W'(LATENCY);
      w_n_vrd_nxt = w_sel_wr;
      w_vd_oe_nxt = w_sel_wr;
      w_n_vwr_nxt = 1'b1;
    end
  end

  // State, strobes and one-cycle pulses; reset drops any in-flight access.
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_state       <= ARB_IDLE;
      r_step        <= '0;
      r_n_vrd       <= 1'b1;
      r_n_vwr       <= 1'b1;
      r_vd_oe       <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_cpu_done    <= 1'b0;
      r_vid_ack     <= 1'b0;
      r_dma_ack     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_step        <= w_step_nxt;
      r_n_vrd       <= w_n_vrd_nxt;
      r_n_vwr       <= w_n_vwr_nxt;
      r_vd_oe       <= w_vd_oe_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      r_cpu_done    <= w_cpu_done_nxt;
      r_vid_ack     <= w_grant && (w_sel_owner == OWN_VID);
      r_dma_ack     <= w_grant && (w_sel_owner == OWN_DMA);
    end
  end

  // Slot registers latch on grant; read data captured at the end of a read slot.
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_owner       <= OWN_NONE;
      r_wr          <= 1'b0;
      r_va          <= '0;
      r_vd_out      <= '0;
      r_rdata       <= '0;
      r_rdata_owner <= OWN_NONE;
    end else begin
      if (w_grant) begin
        r_owner  <= w_sel_owner;
        r_wr     <= w_sel_wr;
        r_va     <= w_sel_addr;
        r_vd_out <= w_sel_wdata;
      end
      if (w_slot_end && !r_wr) begin
        r_rdata       <= vd_in;
        r_rdata_owner <= r_owner;
      end
    end
  end

  assign cpu_wait    = cpu_req && !(w_slot_end && (r_owner == OWN_CPU));
  assign cpu_done    = r_cpu_done;
  assign vid_ack     = r_vid_ack;
  assign dma_ack     = r_dma_ack;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign rdata_owner = r_rdata_owner;
  assign va          = r_va;
  assign vd_out      = r_vd_out;
  assign vd_oe       = r_vd_oe;
  assign n_vrd       = r_n_vrd;
  assign n_vwr       = r_n_vwr;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Bench for sram_slot_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a slot-lifetime reference model.
module tb_sram_slot_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 8;

  logic        clk28 = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, vid_req, vid_urgent, dma_req, dma_wr;
  logic [18:0] cpu_addr, vid_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, vd_in;
  logic        cpu_done, cpu_wait, vid_ack, dma_ack, rdata_valid, vd_oe, n_vrd, n_vwr;
  logic [7:0]  rdata, vd_out;
  logic [1:0]  rdata_owner;
  logic [18:0] va;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: age = cycles since the grant edge (-1 when no slot).
  int          m_age;
  bit          m_wr;
  int          m_own;
  logic [18:0] m_addr;
  logic [7:0]  m_wd;
  int          m_starve;
  bit          e_valid, e_done, e_vack, e_dack;
  logic [7:0]  e_rdata;
  int          e_rown;

  always #5 clk28 = ~clk28;

  sram_slot_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk28(clk28), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_wait(cpu_wait),
    .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_owner(rdata_owner),
    .va(va), .vd_out(vd_out), .vd_oe(vd_oe), .vd_in(vd_in),
    .n_vrd(n_vrd), .n_vwr(n_vwr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    if (vid_urgent && vid_req)          return 2;
    if (dma_req && m_starve >= SMAX)    return 3;
    if (cpu_req)                        return 1;
    if (vid_req)                        return 2;
    if (dma_req)                        return 3;
    return 0;
  endfunction

  // Advance the model across one rising edge using the inputs sampled there.
  task automatic model_edge();
    bit arb;
    int win;
    e_valid = 0; e_done = 0; e_vack = 0; e_dack = 0;
    if (rst) begin
      m_age = -1;
      m_starve = 0;
      return;
    end
    arb = (m_age < 0) || (m_age == LAT && !m_wr);
    if (m_age == LAT) begin
      if (!m_wr) begin
        e_valid = 1;
        e_rdata = vd_in;
        e_rown  = m_own;
      end
      if (m_own == 1) e_done = 1;
    end
    win = arb ? pick_winner() : 0;
    if (!dma_req || win == 3)            m_starve = 0;
    else if (win != 0 && m_starve < SMAX) m_starve++;
    if (win != 0) begin
      m_age = 0;
      m_own = win;
      case (win)
        1:       begin m_wr = cpu_wr; m_addr = cpu_addr; m_wd = cpu_wdata; end
        2:       begin m_wr = 0;      m_addr = vid_addr; m_wd = 8'h00;     end
        default: begin m_wr = dma_wr; m_addr = dma_addr; m_wd = dma_wdata; end
      endcase
      e_vack = (win == 2);
      e_dack = (win == 3);
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age > (m_wr ? LAT + 1 : LAT)) m_age = -1;
    end
  endtask

  task automatic check_outputs();
    bit rd_act, wr_act, vwr_low;
    rd_act  = (m_age >= 0) && !m_wr && (m_age <= LAT);
    wr_act  = (m_age >= 0) && m_wr;
    vwr_low = wr_act && (m_age >= 1) && (m_age <= LAT - 1);
    check_val("n_vrd", 32'(n_vrd), 32'(!rd_act));
    check_val("n_vwr", 32'(n_vwr), 32'(!vwr_low));
    check_val("vd_oe", 32'(vd_oe), 32'(wr_act));
    check_val("strobe_excl", 32'(!n_vrd && (!n_vwr || vd_oe)), 32'(0));
    if (m_age >= 0) check_val("va", 32'(va), 32'(m_addr));
    if (wr_act)     check_val("vd_out", 32'(vd_out), 32'(m_wd));
    check_val("rdata_valid", 32'(rdata_valid), 32'(e_valid));
    if (e_valid) begin
      check_val("rdata", 32'(rdata), 32'(e_rdata));
      check_val("rdata_owner", 32'(rdata_owner), 32'(e_rown));
    end
    check_val("cpu_done", 32'(cpu_done), 32'(e_done));
    check_val("vid_ack", 32'(vid_ack), 32'(e_vack));
    check_val("dma_ack", 32'(dma_ack), 32'(e_dack));
    check_val("cpu_wait", 32'(cpu_wait), 32'(cpu_req && !(m_age == LAT && m_own == 1)));
  endtask

  task automatic tick();
    @(posedge clk28);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic clear_reqs();
    cpu_req = 0; vid_req = 0; dma_req = 0; vid_urgent = 0;
    cpu_wr = 0; dma_wr = 0;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int          k, first_valid, nvrd_low, wait_hi, nvwr_low, done_at, losses;
    bit          stable, got;
    int          owners[$];
    int          ack_at[$];

    m_age = -1; m_starve = 0; m_wr = 0; m_own = 0; m_addr = '0; m_wd = '0;
    e_valid = 0; e_done = 0; e_vack = 0; e_dack = 0; e_rdata = '0; e_rown = 0;
    rst = 1;
    clear_reqs();
    cpu_addr = '0; vid_addr = '0; dma_addr = '0;
    cpu_wdata = '0; dma_wdata = '0; vd_in = '0;

    // Reset state
    tick(); tick();
    check_val("rst_va", 32'(va), 32'(0));
    check_val("rst_vd_out", 32'(vd_out), 32'(0));
    check_val("rst_rdata", 32'(rdata), 32'(0));
    check_val("rst_rdata_owner", 32'(rdata_owner), 32'(0));
    check_val("rst_n_vrd", 32'(n_vrd), 32'(1));
    check_val("rst_n_vwr", 32'(n_vwr), 32'(1));
    rst = 0;
    idle(2);

    // CPU read of 0x7C000 returning 0xA5
    cpu_addr = 19'h7C000; vd_in = 8'hA5; cpu_wr = 0; cpu_req = 1;
    first_valid = -1; nvrd_low = 0; wait_hi = 0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (!n_vrd) nvrd_low++;
      if (cpu_wait) wait_hi++;
      if (rdata_valid && first_valid < 0) begin
        first_valid = t;
        check_val("rd_data", 32'(rdata), 32'hA5);
        check_val("rd_owner", 32'(rdata_owner), 32'(1));
        check_val("rd_done", 32'(cpu_done), 32'(1));
      end
      if (cpu_req && !cpu_wait) cpu_req = 0;
    end
    check_val("rd_nvrd_cycles", 32'(nvrd_low), 32'(3));
    check_val("rd_valid_latency", 32'(first_valid - 1), 32'(3));
    check_val("rd_wait_cycles", 32'(wait_hi), 32'(2));
    idle(2);

    // CPU write 0x12345 <- 0x3C
    cpu_addr = 19'h12345; cpu_wdata = 8'h3C; cpu_wr = 1; cpu_req = 1;
    nvwr_low = 0; done_at = -1; stable = 1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (!n_vwr) begin
        nvwr_low++;
        check_val("wr_strobe_cycle", 32'(t - 1), 32'(1));
      end
      if (t <= 4 && !(va == 19'h12345 && vd_out == 8'h3C && vd_oe)) stable = 0;
      if (cpu_done && done_at < 0) done_at = t;
      if (cpu_req && !cpu_wait) cpu_req = 0;
    end
    check_val("wr_nvwr_cycles", 32'(nvwr_low), 32'(1));
    check_val("wr_hold_stable", 32'(stable), 32'(1));
    check_val("wr_done_in_rec", 32'(done_at - 1), 32'(LAT + 1));
    idle(2);

    // Simultaneous requests, then the same with video urgent
    for (int pass = 0; pass < 2; pass++) begin
      owners = {};
      cpu_addr = 19'h00111; vid_addr = 19'h00222; dma_addr = 19'h00333;
      cpu_wr = 0; dma_wr = 0; vd_in = 8'h44;
      vid_urgent = (pass == 1);
      cpu_req = 1; vid_req = 1; dma_req = 1;
      for (k = 0; k < 30 && owners.size() < 3; k++) begin
        tick();
        if (rdata_valid) owners.push_back(int'(rdata_owner));
        if (cpu_req && !cpu_wait) cpu_req = 0;
        if (vid_ack) vid_req = 0;
        if (dma_ack) dma_req = 0;
        vd_in = 8'($urandom);
      end
      while (owners.size() < 3) owners.push_back(0);
      check_val(pass ? "urg_first" : "ord_first", 32'(owners[0]), pass ? 32'(2) : 32'(1));
      check_val(pass ? "urg_second" : "ord_second", 32'(owners[1]), pass ? 32'(1) : 32'(2));
      check_val(pass ? "urg_third" : "ord_third", 32'(owners[2]), 32'(3));
      idle(3);
    end

    // DMA starvation promotion under continuous CPU and video traffic
    cpu_req = 1; vid_req = 1; dma_req = 1; cpu_wr = 0; dma_wr = 0;
    losses = 0; got = 0;
    for (k = 0; k < 80 && !got; k++) begin
      tick();
      if (rdata_valid) begin
        if (rdata_owner == 2'd3) got = 1;
        else losses++;
      end
      if (dma_ack) dma_req = 0;
    end
    check_val("starve_dma_served", 32'(got), 32'(1));
    check_val("starve_losses", 32'(losses), 32'(SMAX));
    idle(4);

    // Back-to-back video reads
    ack_at = {};
    vid_req = 1;
    for (int t = 1; t <= 12; t++) begin
      vid_addr = 19'($urandom);
      tick();
      if (vid_ack) ack_at.push_back(t);
    end
    while (ack_at.size() < 4) ack_at.push_back(-100);
    check_val("b2b_ack_count_min", 32'(ack_at.size() >= 4), 32'(1));
    for (int i = 1; i < 4; i++) check_val("b2b_spacing", 32'(ack_at[i] - ack_at[i-1]), 32'(LAT + 1));
    idle(3);

    // Reset during the strobe cycle of a write
    cpu_addr = 19'h55555; cpu_wdata = 8'h99; cpu_wr = 1; cpu_req = 1;
    tick();
    tick();
    check_val("rstmid_strobe_low", 32'(n_vwr), 32'(0));
    rst = 1; cpu_req = 0;
    tick();
    check_val("rstmid_nvwr", 32'(n_vwr), 32'(1));
    check_val("rstmid_vd_oe", 32'(vd_oe), 32'(0));
    check_val("rstmid_done", 32'(cpu_done), 32'(0));
    rst = 0;
    idle(3);
    cpu_addr = 19'h00ABC; cpu_wr = 0; vd_in = 8'h5A; cpu_req = 1;
    got = 0;
    for (k = 0; k < 10 && !got; k++) begin
      tick();
      if (rdata_valid) begin
        got = 1;
        check_val("rstmid_fresh_data", 32'(rdata), 32'h5A);
        check_val("rstmid_fresh_owner", 32'(rdata_owner), 32'(1));
      end
      if (cpu_req && !cpu_wait) cpu_req = 0;
    end
    check_val("rstmid_fresh_served", 32'(got), 32'(1));
    idle(2);

    // Randomized traffic against the model
    for (int t = 0; t < 4000; t++) begin
      if ($urandom_range(0, 7) == 0) cpu_req = !cpu_req;
      if ($urandom_range(0, 7) == 0) vid_req = !vid_req;
      if ($urandom_range(0, 7) == 0) vid_urgent = !vid_urgent;
      if (dma_ack) dma_req = 0;
      else if (!dma_req && $urandom_range(0, 9) == 0) dma_req = 1;
      cpu_wr    = 1'($urandom);
      dma_wr    = 1'($urandom);
      cpu_addr  = 19'($urandom);
      vid_addr  = 19'($urandom);
      dma_addr  = 19'($urandom);
      cpu_wdata = 8'($urandom);
      dma_wdata = 8'($urandom);
      vd_in     = 8'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
